// File: rtl/cim_timestep_scheduler.sv
// Timestep sequencer for a compute-in-memory neuron array: runs spike drain,
// accumulator swap and per-neuron current readout for a programmed number of steps.

module cim_timestep_scheduler #(
    parameter int TAGBITS  = 4,
    parameter int NUMWIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_start,
    input  logic [15:0]         i_num_steps,

    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [TAGBITS-1:0]  i_cfg_src,
    input  logic [TAGBITS-1:0]  i_cfg_dst,
    input  logic [7:0]          i_cfg_weight,

    output logic                o_cim_ld_en,
    output logic [TAGBITS-1:0]  o_cim_eff_tag,
    output logic [TAGBITS-1:0]  o_cim_aff_tag,
    output logic [7:0]          o_cim_ld_weight,

    input  logic                i_cim_busy,
    input  logic                i_cim_fifo_empty,
    output logic                o_cim_swap,

    output logic                o_cim_read_en,
    output logic [TAGBITS-1:0]  o_cim_i_tag,
    input  logic [NUMWIDTH:0]   i_cim_i_out,

    output logic                o_step_start,
    input  logic                i_spk_done,

    output logic                o_cur_valid,
    input  logic                i_cur_ready,
    output logic [TAGBITS-1:0]  o_cur_tag,
    output logic [NUMWIDTH:0]   o_cur_value,

    output logic [15:0]         o_step_count,
    output logic                o_done,
    output logic [3:0]          o_phase
);

    // state      | meaning
    // IDLE       | waiting for start; weight programming allowed
    // STEP       | one-cycle step_start pulse to spike producer
    // DRAIN      | wait for producer done, spike FIFO empty and CIM idle
    // SWAP       | one-cycle swap request to CIM
    // SWAP_WAIT  | wait for CIM to finish the swap
    // RD_ISSUE   | read request for neuron k
    // RD_WAIT    | CIM read latency
    // RD_CAP     | capture readout into cur_tag / cur_value
    // RD_PRESENT | hold current until the neuron engine accepts it
    // FINISH     | one-cycle done pulse
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_STEP       = 4'd1,
        S_DRAIN      = 4'd2,
        S_SWAP       = 4'd3,
        S_SWAP_WAIT  = 4'd4,
        S_RD_ISSUE   = 4'd5,
        S_RD_WAIT    = 4'd6,
        S_RD_CAP     = 4'd7,
        S_RD_PRESENT = 4'd8,
        S_FINISH     = 4'd9
    } state_t;

    localparam logic [TAGBITS-1:0] LAST_TAG = '1;

    state_t               r_state;
    logic [15:0]          r_num_steps;
    logic [15:0]          r_step_count;
    logic [TAGBITS-1:0]   r_k;
    logic                 r_spk_flag;
    logic [TAGBITS-1:0]   r_cur_tag;
    logic [NUMWIDTH:0]    r_cur_value;
    logic [TAGBITS-1:0]   r_cim_i_tag;

    state_t               w_state_nxt;
    logic [15:0]          w_num_steps_nxt;
    logic [15:0]          w_step_count_nxt;
    logic [15:0]          w_step_count_inc;
    logic [TAGBITS-1:0]   w_k_nxt;
    logic                 w_spk_flag_nxt;
    logic [TAGBITS-1:0]   w_cur_tag_nxt;
    logic [NUMWIDTH:0]    w_cur_value_nxt;
    logic [TAGBITS-1:0]   w_cim_i_tag_nxt;

    logic                 w_step_start;
    logic                 w_swap;
    logic                 w_read_en;
    logic                 w_cur_valid;
    logic                 w_done;
    logic                 w_cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_num_steps  <= '0;
            r_step_count <= '0;
            r_k          <= '0;
            r_spk_flag   <= 1'b0;
            r_cur_tag    <= '0;
            r_cur_value  <= '0;
            r_cim_i_tag  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_num_steps  <= w_num_steps_nxt;
            r_step_count <= w_step_count_nxt;
            r_k          <= w_k_nxt;
            r_spk_flag   <= w_spk_flag_nxt;
            r_cur_tag    <= w_cur_tag_nxt;
            r_cur_value  <= w_cur_value_nxt;
            r_cim_i_tag  <= w_cim_i_tag_nxt;
        end
    end

    assign w_step_count_inc = r_step_count + 16'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_num_steps_nxt  = r_num_steps;
        w_step_count_nxt = r_step_count;
        w_k_nxt          = r_k;
        w_spk_flag_nxt   = r_spk_flag;
        w_cur_tag_nxt    = r_cur_tag;
        w_cur_value_nxt  = r_cur_value;
        w_cim_i_tag_nxt  = r_cim_i_tag;
        w_step_start     = 1'b0;
        w_swap           = 1'b0;
        w_read_en        = 1'b0;
        w_cur_valid      = 1'b0;
        w_done           = 1'b0;
        w_cfg_ready      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (i_start) begin
                    w_num_steps_nxt  = i_num_steps;
                    w_step_count_nxt = '0;
                    w_k_nxt          = '0;
                    w_state_nxt      = (i_num_steps == 16'd0) ? S_FINISH : S_STEP;
                end
            end
            S_STEP: begin
                w_step_start   = 1'b1;
                // a producer that finishes within the start cycle must not be lost
                w_spk_flag_nxt = i_spk_done;
                w_state_nxt    = S_DRAIN;
            end
            S_DRAIN: begin
                w_spk_flag_nxt = r_spk_flag | i_spk_done;
                if (r_spk_flag && i_cim_fifo_empty && !i_cim_busy) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                w_swap      = 1'b1;
                w_state_nxt = S_SWAP_WAIT;
            end
            S_SWAP_WAIT: begin
                if (!i_cim_busy) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                w_read_en       = 1'b1;
                w_cim_i_tag_nxt = r_k;
                w_state_nxt     = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_cur_value_nxt = i_cim_i_out;
                w_cur_tag_nxt   = r_k;
                w_state_nxt     = S_RD_PRESENT;
            end
            S_RD_PRESENT: begin
                w_cur_valid = 1'b1;
                if (i_cur_ready) begin
                    if (r_k != LAST_TAG) begin
                        w_k_nxt     = r_k + TAGBITS'(1);
                        w_state_nxt = S_RD_ISSUE;
                    end else begin
                        w_k_nxt          = '0;
                        w_step_count_nxt = w_step_count_inc;
                        w_state_nxt      = (w_step_count_inc == r_num_steps) ? S_FINISH : S_STEP;
                    end
                end
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // strobes are masked while reset is held so an abandoned run emits nothing more
    assign o_step_start    = w_step_start & ~reset;
    assign o_cim_swap      = w_swap & ~reset;
    assign o_cim_read_en   = w_read_en & ~reset;
    assign o_done          = w_done & ~reset;
    assign o_cur_valid     = w_cur_valid & ~reset;

    assign o_cfg_ready     = w_cfg_ready;
    assign o_cim_ld_en     = i_cfg_valid & w_cfg_ready;
    assign o_cim_eff_tag   = i_cfg_src;
    assign o_cim_aff_tag   = i_cfg_dst;
    assign o_cim_ld_weight = i_cfg_weight;

    assign o_cim_i_tag     = w_read_en ? r_k : r_cim_i_tag;
    assign o_cur_tag       = r_cur_tag;
    assign o_cur_value     = r_cur_value;
    assign o_step_count    = r_step_count;
    assign o_phase         = r_state;

endmodule
